// File: rtl/ads_sample_capture.sv
// Per-channel ADS ADC sampler: each AFE_CLK rise runs settle, convert and a 16-bit serial read,
// then emits the tagged word with a one-cycle strobe. AFE_IRST rise restarts the frame.
module ads_sample_capture #(
  parameter int CH_NUM   = 64,   // at most 64: DATA_CH is 6 bits wide
  parameter int T_SETTLE = 20,
  parameter int T_CONVST = 5,
  parameter int T_CONV   = 30,
  parameter int SCLK_DIV = 1
) (
  input  logic        CLK_100M,
  input  logic        CLK_RST_N,
  input  logic        ADS_INIT_OK,
  input  logic        AFE_CLK,
  input  logic        AFE_IRST,
  output logic        ADS_CONVST,
  output logic        ADS_CS_N,
  output logic        ADS_SCLK,
  input  logic        ADS_SDO,
  output logic [15:0] DATA_OUT,
  output logic [5:0]  DATA_CH,
  output logic        DATA_VALID,
  output logic        FRAME_DONE,
  output logic        OVERRUN,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_CONVST    = 3'd2,
    S_CONV_WAIT = 3'd3,
    S_SHIFT     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [7:0]  half_q, half_d;
  logic        sclk_q, sclk_d;
  logic [4:0]  bits_q, bits_d;
  logic [15:0] shift_q, shift_d;
  logic [6:0]  ch_q, ch_d;
  logic [15:0] data_q, data_d;
  logic [5:0]  dch_q, dch_d;
  logic        ovr_q, ovr_d;
  logic        afe_clk_q, afe_irst_q;
  logic        clk_rise, irst_rise;

  assign clk_rise  = AFE_CLK & ~afe_clk_q;
  assign irst_rise = AFE_IRST & ~afe_irst_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    half_d  = half_q;
    sclk_d  = sclk_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    ch_d    = ch_q;
    data_d  = data_q;
    dch_d   = dch_q;
    ovr_d   = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (clk_rise && ADS_INIT_OK && (ch_q < 7'(CH_NUM))) begin
          state_d = S_SETTLE;
          tmr_d   = 8'd0;
        end
      end
      S_SETTLE: begin
        if (tmr_q == 8'(T_SETTLE - 1)) begin
          state_d = S_CONVST;
          tmr_d   = 8'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_CONVST: begin
        if (tmr_q == 8'(T_CONVST - 1)) begin
          state_d = S_CONV_WAIT;
          tmr_d   = 8'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_CONV_WAIT: begin
        if (tmr_q == 8'(T_CONV - 1)) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          half_d  = 8'd0;
          bits_d  = 5'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_SHIFT: begin
        // The first high half after CS_N falls is chip-select setup; each low-to-high
        // toggle afterwards is an SCLK rise and captures one SDO bit.
        if (half_q == 8'(SCLK_DIV - 1)) begin
          half_d = 8'd0;
          if (sclk_q) begin
            if (bits_q == 5'd16) begin
              state_d = S_DONE;
              data_d  = shift_q;
              dch_d   = ch_q[5:0];
            end else begin
              sclk_d = 1'b0;
            end
          end else begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[14:0], ADS_SDO};
            bits_d  = bits_q + 5'd1;
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (ch_q < 7'(CH_NUM)) ch_d = ch_q + 7'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (clk_rise && (state_q != S_IDLE)) ovr_d = 1'b1;

    // Frame restart beats everything, including a coincident AFE_CLK edge.
    if (irst_rise) begin
      state_d = S_IDLE;
      ch_d    = 7'd0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK_100M) begin
    if (!CLK_RST_N) begin
      state_q    <= S_IDLE;
      tmr_q      <= 8'd0;
      half_q     <= 8'd0;
      sclk_q     <= 1'b1;
      bits_q     <= 5'd0;
      shift_q    <= 16'd0;
      ch_q       <= 7'd0;
      data_q     <= 16'd0;
      dch_q      <= 6'd0;
      ovr_q      <= 1'b0;
      afe_clk_q  <= 1'b0;
      afe_irst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      half_q     <= half_d;
      sclk_q     <= sclk_d;
      bits_q     <= bits_d;
      shift_q    <= shift_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      dch_q      <= dch_d;
      ovr_q      <= ovr_d;
      afe_clk_q  <= AFE_CLK;
      afe_irst_q <= AFE_IRST;
    end
  end

  assign ADS_CONVST  = (state_q == S_CONVST);
  assign ADS_CS_N    = (state_q != S_SHIFT);
  assign ADS_SCLK    = (state_q == S_SHIFT) ? sclk_q : 1'b1;
  assign DATA_VALID  = (state_q == S_DONE);
  assign FRAME_DONE  = (state_q == S_DONE) && (ch_q == 7'(CH_NUM - 1));
  assign DATA_OUT    = data_q;
  assign DATA_CH     = dch_q;
  assign OVERRUN     = ovr_q;
  assign dbg_state_o = state_q;

endmodule
